tilt_debounce_array: RTL and testbench
======================================

TILT_DEBOUNCE_ARRAY -- requirements
Module: tilt_debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent ball-switch channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL have parameter CNT_W, default 8: width of each per-channel event counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sensor  input  N_CH  raw asynchronous ball-switch levels, high = tilted.
REQ-007 SHALL have port mode  input  2  LED mode shared by all channels: 00 FOLLOW, 01 TOGGLE, 10 LATCH, 11 treated as FOLLOW.
REQ-008 SHALL have port clear  input  1  synchronous clear of LATCH LEDs and event counters.
REQ-009 SHALL have port led  output  N_CH  per-channel LED drive, registered.
REQ-010 SHALL have port tilt_stable  output  N_CH  debounced sensor level.
REQ-011 SHALL have port tilt_pulse  output  N_CH  one-cycle strobe on each debounced 0->1 transition.
REQ-012 SHALL have port evt_count  output  N_CH*CNT_W  per-channel count of tilt_pulse events, channel i at bits [i*CNT_W +: CNT_W] (present only per REQ-030).

Function
REQ-013 Each sensor bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each channel SHALL run a debounce FSM with states STABLE_LO, ARM_HI, STABLE_HI, ARM_LO.
REQ-015 STABLE_LO -> ARM_HI when synced=1, clearing the debounce counter; STABLE_HI -> ARM_LO when synced=0, likewise.
REQ-016 In ARM_x, the counter SHALL increment each cycle synced holds the new level; on synced reverting, return to the previous STABLE state with counter cleared.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 while armed, the FSM SHALL enter the new STABLE state and tilt_stable SHALL update on that edge.
REQ-018 Latency: a clean sensor step SHALL appear on tilt_stable exactly 2 + DEBOUNCE_CYCLES cycles later; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-019 tilt_pulse SHALL be high for exactly the one cycle after tilt_stable rises; never on a fall.
REQ-020 FOLLOW: led SHALL equal tilt_stable registered one cycle later.
REQ-021 TOGGLE: led SHALL invert on the cycle after each tilt_pulse.
REQ-022 LATCH: led SHALL set on the cycle after tilt_pulse and hold until clear; clear and tilt_pulse in the same cycle SHALL leave led set.
REQ-023 Any change of mode SHALL clear all led bits for one cycle, after which the new mode applies from the current tilt_stable state.
REQ-024 evt_count SHALL increment by 1 per tilt_pulse and saturate at 2^CNT_W-1 (no wrap).
REQ-025 clear coinciding with tilt_pulse SHALL load evt_count to 1 (event not lost); clear alone loads 0.
REQ-026 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be honoured.

Reset
REQ-027 On rst high: synchronizers 0, FSMs STABLE_LO, debounce counters 0, led 0, tilt_stable 0, tilt_pulse 0, evt_count 0.
REQ-028 Reset asserted mid-debounce SHALL abandon the pending change; after release, a sensor held high SHALL require the full 2 + DEBOUNCE_CYCLES latency.
REQ-029 Reset release SHALL produce no tilt_pulse unless a debounced rise subsequently occurs.

Configuration
REQ-030 Macro TILT_EVENT_CNT_EN defined: evt_count port and counters SHALL exist per REQ-024/025; undefined: the port and counters SHALL be absent and clear SHALL affect only LATCH LEDs.

Structure
REQ-031 A shared package tilt_pkg SHALL hold the FSM state enum, the mode encoding constants, and a function computing debounce counter width as clog2(DEBOUNCE_CYCLES).
REQ-032 The synchronizer plus debounce FSM SHALL be a sub-module tilt_debounce_ch, instantiated N_CH times by generate; LED mode logic and counters stay in the top.

Verification (N_CH=2, DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-033 sensor[0] 0->1 held -> tilt_stable[0] high at cycle 6, tilt_pulse[0] at cycle 7 only, led[0]=1 at 7 in FOLLOW.
REQ-034 sensor[1] high for 3 cycles then low -> tilt_stable[1], tilt_pulse[1], led[1] remain 0.
REQ-035 TOGGLE, three clean tilts on ch0 -> led[0] sequence 1,0,1; ch1 unaffected.
REQ-036 LATCH, tilt then release on ch0 -> led[0] stays 1 until clear; clear with simultaneous pulse -> led[0] stays 1, evt_count ch0 = 1.
REQ-037 Nine tilts on ch1 -> evt_count ch1 saturates at 7; rst asserted while ch0 armed -> all outputs 0, no pulse after release until 6 cycles of high sensor.

Source files
------------

// File: rtl/tilt_pkg.sv
// tilt_pkg -- shared definitions for the tilt debounce array.
//   deb_state_t : per-channel debounce FSM states
//   MODE_*      : LED mode encodings (2'b11 is folded onto FOLLOW by the top)
//   deb_cnt_w() : debounce counter width, clog2(DEBOUNCE_CYCLES), minimum 1
package tilt_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } deb_state_t;

  localparam logic [1:0] MODE_FOLLOW = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_LATCH  = 2'b10;

  function automatic int deb_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tilt_debounce_ch.sv
// tilt_debounce_ch -- one ball-switch channel: 2-flop synchronizer followed by
// a four-state debounce FSM.
// Ports:
//   clk, rst     : clock, async active-high reset
//   sensor       : raw asynchronous switch level (high = tilted)
//   tilt_stable  : debounced level, registered
//   tilt_pulse   : one-cycle strobe the cycle after tilt_stable rises
module tilt_debounce_ch
  import tilt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic tilt_stable,
  output logic tilt_pulse
);

  localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);
  // Entering ARM spends one cycle with the counter at 0, so leaving on the
  // edge where the count would reach DEBOUNCE_CYCLES-1 yields a total
  // latency of 2 (sync) + DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync_q;
  logic          synced;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic          pulse_q;

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      state_q       <= STABLE_LO;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], sensor};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      pulse_q       <= stable_q & ~stable_prev_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      STABLE_LO: begin
        if (synced) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!synced) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          stable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!synced) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (synced) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = STABLE_LO;
        cnt_d    = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  assign tilt_stable = stable_q;
  assign tilt_pulse  = pulse_q;

endmodule

// File: rtl/tilt_debounce_array.sv
// tilt_debounce_array -- N_CH independent debounced ball-switch channels with
// a shared LED mode and optional per-channel event counters.
// Optional feature: define TILT_EVENT_CNT_EN to build the evt_count port and
// saturating counters; without it, clear only affects LATCH LEDs.
// Ports:
//   clk, rst     : clock, async active-high reset
//   sensor       : raw switch levels, one per channel
//   mode         : 00 FOLLOW, 01 TOGGLE, 10 LATCH, 11 = FOLLOW
//   clear        : sync clear of LATCH LEDs (and counters when built)
//   led          : registered LED drive per channel
//   tilt_stable  : debounced levels
//   tilt_pulse   : one-cycle rise strobes
//   evt_count    : CNT_W-bit count per channel (TILT_EVENT_CNT_EN only)
module tilt_debounce_array
  import tilt_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sensor,
  input  logic [1:0]        mode,
  input  logic              clear,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   tilt_stable,
  output logic [N_CH-1:0]   tilt_pulse
`ifdef TILT_EVENT_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] evt_count
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tilt_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sensor     (sensor[i]),
      .tilt_stable(tilt_stable[i]),
      .tilt_pulse (tilt_pulse[i])
    );
  end

  // 11 is folded onto FOLLOW up front so 00<->11 is not seen as a mode change.
  logic [1:0] mode_eff;
  logic [1:0] mode_q;

  assign mode_eff = (mode == 2'b11) ? MODE_FOLLOW : mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_FOLLOW;
      led    <= '0;
    end else begin
      mode_q <= mode_eff;
      if (mode_eff != mode_q) begin
        // Blank every LED for one cycle on a mode switch.
        led <= '0;
      end else begin
        case (mode_q)
          MODE_TOGGLE: led <= led ^ tilt_pulse;
          // A pulse coinciding with clear wins so the event is not lost.
          MODE_LATCH:  led <= clear ? tilt_pulse : (led | tilt_pulse);
          default:     led <= tilt_stable;
        endcase
      end
    end
  end

`ifdef TILT_EVENT_CNT_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (clear)
        cnt_q <= CNT_W'(tilt_pulse[i]);
      else if (tilt_pulse[i] && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
    assign evt_count[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_tilt_debounce_array.sv
module tb_tilt_debounce_array;
  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int CW   = 3;

  localparam int S_STB = 0, S_PUL = 1, S_LED = 2, S_CNT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] sensor;
  logic [1:0]      mode;
  logic            clear;
  logic [N_CH-1:0] led, tilt_stable, tilt_pulse;
`ifdef TILT_EVENT_CNT_EN
  logic [N_CH*CW-1:0] evt_count;
`endif

  tilt_debounce_array #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .mode(mode), .clear(clear),
    .led(led), .tilt_stable(tilt_stable), .tilt_pulse(tilt_pulse)
`ifdef TILT_EVENT_CNT_EN
    , .evt_count(evt_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sig;
    int    ch;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int get_sig(input int sig, input int ch);
    case (sig)
      S_STB: return int'(tilt_stable[ch]);
      S_PUL: return int'(tilt_pulse[ch]);
      S_LED: return int'(led[ch]);
`ifdef TILT_EVENT_CNT_EN
      S_CNT: return int'(evt_count[ch*CW +: CW]);
`endif
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        int act;
        act = get_sig(q[i].sig, q[i].ch);
        n_cmp++;
        if (q[i].at < cyc || act != q[i].val) begin
          n_bad++;
          $display("FAIL %s ch%0d @cyc %0d: got %0d, expected %0d",
                   q[i].nm, q[i].ch, q[i].at, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int dc, input int sig, input int ch, input int val, input string nm);
    exp_t e;
    e.at = cyc + dc; e.sig = sig; e.ch = ch; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tilt(input int ch);
    sensor[ch] = 1'b1;
    step(8);
    sensor[ch] = 1'b0;
    step(8);
  endtask

  task automatic push_all_zero(input string nm);
    for (int c = 0; c < N_CH; c++) begin
      push(0, S_STB, c, 0, nm);
      push(0, S_PUL, c, 0, nm);
      push(0, S_LED, c, 0, nm);
`ifdef TILT_EVENT_CNT_EN
      push(0, S_CNT, c, 0, nm);
`endif
    end
  endtask

  initial begin
    int prev, nxt;
    rst = 1'b1; sensor = '0; mode = 2'b00; clear = 1'b0;
    step(2);
    push_all_zero("reset_state");
    n_cmp++;
    if (tilt_stable !== '0) begin
      n_bad++;
      $display("FAIL reset tilt_stable: got %b", tilt_stable);
    end
    n_cmp++;
    if (tilt_pulse !== '0) begin
      n_bad++;
      $display("FAIL reset tilt_pulse: got %b", tilt_pulse);
    end
    n_cmp++;
    if (led !== '0) begin
      n_bad++;
      $display("FAIL reset led: got %b", led);
    end
`ifdef TILT_EVENT_CNT_EN
    n_cmp++;
    if (evt_count !== '0) begin
      n_bad++;
      $display("FAIL reset evt_count: got %h", evt_count);
    end
`endif
    step(1);
    rst = 1'b0;
    step(1);

    sensor[0] = 1'b1;
    push(5, S_STB, 0, 0, "rise_stable_early");
    push(6, S_STB, 0, 1, "rise_stable");
    push(6, S_PUL, 0, 0, "rise_pulse_early");
    push(7, S_PUL, 0, 1, "rise_pulse");
    push(8, S_PUL, 0, 0, "rise_pulse_once");
    push(6, S_LED, 0, 0, "follow_led_early");
    push(7, S_LED, 0, 1, "follow_led");
`ifdef TILT_EVENT_CNT_EN
    push(8, S_CNT, 0, 1, "cnt_first");
`endif
    step(10);

    sensor[1] = 1'b1;
    for (int d = 1; d <= 12; d++) begin
      push(d, S_STB, 1, 0, "glitch_stable");
      push(d, S_PUL, 1, 0, "glitch_pulse");
    end
    push(12, S_LED, 1, 0, "glitch_led");
    step(3);
    sensor[1] = 1'b0;
    step(12);

    sensor[0] = 1'b0;
    push(5, S_STB, 0, 1, "fall_stable_early");
    push(6, S_STB, 0, 0, "fall_stable");
    push(7, S_PUL, 0, 0, "fall_no_pulse");
    push(6, S_LED, 0, 1, "fall_led_early");
    push(7, S_LED, 0, 0, "fall_led");
    step(10);

    mode = 2'b01;
    push(1, S_LED, 0, 0, "toggle_modechg");
    step(2);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      nxt = prev ^ 1;
      push(7, S_LED, 0, prev, "toggle_before");
      push(8, S_LED, 0, nxt, "toggle_after");
      push(8, S_LED, 1, 0, "toggle_ch1_idle");
      tilt(0);
      prev = nxt;
    end

    mode = 2'b10;
    push(0, S_LED, 0, 1, "latch_pre_modechg");
    push(1, S_LED, 0, 0, "latch_modechg_blank");
    step(2);
    push(8, S_LED, 0, 1, "latch_set");
    push(15, S_LED, 0, 1, "latch_hold");
`ifdef TILT_EVENT_CNT_EN
    push(8, S_CNT, 0, 5, "cnt_five");
`endif
    tilt(0);
    clear = 1'b1;
    push(1, S_LED, 0, 0, "latch_clear");
`ifdef TILT_EVENT_CNT_EN
    push(0, S_CNT, 0, 5, "cnt_pre_clear");
    push(1, S_CNT, 0, 0, "cnt_clear");
`endif
    step(1);
    clear = 1'b0;
    step(2);

    sensor[0] = 1'b1;
    step(7);
    clear = 1'b1;
    push(0, S_PUL, 0, 1, "clr_pulse_present");
    push(1, S_LED, 0, 1, "clr_pulse_led");
`ifdef TILT_EVENT_CNT_EN
    push(1, S_CNT, 0, 1, "clr_pulse_cnt");
`endif
    step(1);
    clear = 1'b0;
    step(1);
    sensor[0] = 1'b0;
    step(8);

    for (int k = 1; k <= 9; k++) begin
`ifdef TILT_EVENT_CNT_EN
      push(8, S_CNT, 1, (k > 7) ? 7 : k, "sat_cnt");
`endif
      tilt(1);
    end
    push(0, S_LED, 1, 1, "latch_ch1");

    sensor[0] = 1'b1;
    step(4);
    rst = 1'b1;
    push_all_zero("midarm_reset");
    step(2);
    n_cmp++;
    if (tilt_stable !== '0) begin
      n_bad++;
      $display("FAIL midarm reset tilt_stable: got %b", tilt_stable);
    end
    n_cmp++;
    if (tilt_pulse !== '0) begin
      n_bad++;
      $display("FAIL midarm reset tilt_pulse: got %b", tilt_pulse);
    end
    n_cmp++;
    if (led !== '0) begin
      n_bad++;
      $display("FAIL midarm reset led: got %b", led);
    end
    rst = 1'b0;
    for (int d = 1; d <= 6; d++) push(d, S_PUL, 0, 0, "post_rst_no_pulse");
    push(5, S_STB, 0, 0, "post_rst_stable_early");
    push(6, S_STB, 0, 1, "post_rst_stable");
    push(7, S_PUL, 0, 1, "post_rst_pulse");
    push(8, S_PUL, 0, 0, "post_rst_pulse_once");
    push(8, S_LED, 0, 1, "post_rst_latch");
`ifdef TILT_EVENT_CNT_EN
    push(8, S_CNT, 0, 1, "post_rst_cnt");
`endif
    step(12);

    step(2);
    foreach (q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s ch%0d: expectation for cyc %0d never checked", q[i].nm, q[i].ch, q[i].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
